uart_cmd_parser: RTL
====================

# uart_cmd_parser

Frame parser that sits directly downstream of the UART receiver. It consumes the receiver's one-cycle byte-valid strobe and byte, and assembles framed register-write commands: header, address, length, payload, checksum. It buffers the payload and releases register writes only after the checksum verifies. Its write port drives the design's register file; it also reports frame success and error events.

## Interface
- CLKS_TIMEOUT, 100000: maximum clocks allowed between consecutive bytes inside a frame; legal range 2..2^24.
- MAX_LEN, 16: maximum payload bytes per frame; legal range 1..255.
- HEADER, 8'hAA: start-of-frame byte.

Ports:
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_Rx_DV  in  1  byte-valid strobe, high for one cycle per received byte.
- i_Rx_Byte  in  8  received byte; valid when i_Rx_DV=1.
- o_Wr_En  out  1  register write strobe.
- o_Wr_Addr  out  8  write address; valid with o_Wr_En.
- o_Wr_Data  out  8  write data; valid with o_Wr_En.
- o_Frame_Ok  out  1  one-cycle pulse: frame accepted and all writes issued.
- o_Frame_Err  out  1  one-cycle pulse: frame discarded.
- o_Err_Code  out  2  error code: 00 none, 01 checksum, 10 length, 11 timeout.
- o_Busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ADDR, LEN, DATA, CSUM, REPLAY.
- IDLE:
  - A byte equal to HEADER moves the FSM to ADDR.
  - Any other byte is ignored; no error is raised.
- ADDR: latch the byte as the base address; go to LEN.
- LEN:
  - Length 1..MAX_LEN: latch it, clear the payload index, go to DATA.
  - Length 0 or length > MAX_LEN: o_Frame_Err pulse, o_Err_Code=10, go to IDLE.
- DATA:
  - Store each byte into buffer[index]; the buffer is MAX_LEN x 8.
  - After LEN bytes, go to CSUM.
  - A HEADER value inside the payload is ordinary data; there is no escaping.
- CSUM:
  - Running sum = (addr + len + all payload bytes) mod 256, 8-bit wrapping add.
  - Received byte equals sum: go to REPLAY.
  - Otherwise: o_Frame_Err pulse, o_Err_Code=01, go to IDLE. No writes are issued.
- REPLAY:
  - o_Wr_En is high for exactly LEN consecutive cycles.
  - Write k (k=0..LEN-1): o_Wr_Addr=(addr+k) mod 256, wrapping 8'hFF to 8'h00; o_Wr_Data=buffer[k].
  - After the last write: o_Frame_Ok pulse, o_Err_Code=00, go to IDLE.
  - i_Rx_DV during REPLAY is dropped.
- Inter-byte timeout:
  - Active in ADDR, LEN, DATA and CSUM; counter is 24 bits.
  - The counter clears on entry to ADDR and on every i_Rx_DV.
  - When it reaches CLKS_TIMEOUT-1 with no byte: o_Frame_Err pulse, o_Err_Code=11, go to IDLE.
  - A timeout and an i_Rx_DV in the same cycle: the byte wins.
- o_Err_Code holds its value until the next o_Frame_Err or o_Frame_Ok.

## Timing
- Reset value of every output is 0. FSM resets to IDLE; counters and index reset to 0. Buffer contents are don't-care.
- Reset asserted mid-frame or mid-REPLAY: outputs clear immediately. No further writes are issued and the partial frame is lost.
- Header DV at cycle N: o_Busy=1 from N+1.
- Outputs are registered, so o_Frame_Err for a bad length appears at cycle L+1, where L is the cycle of the length byte's DV.
- Checksum DV at cycle C:
  - Pass: o_Wr_En high for cycles C+1..C+LEN; o_Frame_Ok at C+LEN+1; o_Busy=0 from C+LEN+2.
  - Fail: o_Frame_Err at C+1; o_Busy=0 from C+2.
- Timeout: o_Frame_Err exactly CLKS_TIMEOUT cycles after the last accepted DV, or after entry to ADDR.
- The FSM is in IDLE one cycle after any error pulse, so a HEADER byte arriving on the following DV starts a new frame.

## Test plan
- Good frame: stream AA 10 03 11 22 33 79, junk 55 00 before the header -> writes (10,11),(11,22),(12,33) on 3 consecutive cycles, then o_Frame_Ok, o_Err_Code=00.
- Bad checksum: AA 10 03 11 22 33 78 -> no o_Wr_En, o_Frame_Err one cycle after last DV, o_Err_Code=01.
- Length errors with MAX_LEN=16:
  - AA 10 00 -> o_Frame_Err, code 10.
  - AA 10 11 (length 17) -> o_Frame_Err, code 10.
  - A following good frame is fully accepted.
- Address wrap: AA FE 03 01 02 03 07 -> writes (FE,01),(FF,02),(00,03), then o_Frame_Ok.
- Timeout with CLKS_TIMEOUT=50: AA 10 then idle -> o_Frame_Err with code 11 exactly 50 cycles after the 10 DV; a byte arriving at cycle 49 keeps the frame alive.
- Reset during REPLAY of an 8-byte frame: assert i_Rst_n=0 after write 3 -> o_Wr_En drops without waiting for a clock edge, all outputs 0, no o_Frame_Ok; the next good frame after release is accepted.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Assembles framed register-write commands from the UART receiver byte stream:
//   HEADER, addr, len, payload[len], checksum
// The payload is buffered and written out only after the checksum matches
// (addr + len + payload) mod 256. Errors are reported with a one-cycle
// o_Frame_Err pulse and a sticky o_Err_Code; success with o_Frame_Ok.
//
// Input handshake: i_Rx_DV is a single-cycle strobe with no back-pressure.
// A byte is consumed on the rising edge where i_Rx_DV=1. Bytes arriving
// while the write burst is being replayed are dropped.
//
// o_Busy covers every non-IDLE state plus the cycle that carries the
// closing o_Frame_Ok / o_Frame_Err pulse, so the frame is reported busy
// until its outcome has been presented.
module uart_cmd_parser #(
    parameter int         CLKS_TIMEOUT = 100000,
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] HEADER       = 8'hAA
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Wr_En,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic       o_Frame_Ok,
    output logic       o_Frame_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        LEN    = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        REPLAY = 3'd5
    } state_t;

    localparam int          IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    // Timeout fires on the edge where the counter would step to CLKS_TIMEOUT-1,
    // which puts the error pulse exactly CLKS_TIMEOUT cycles after the last byte.
    localparam logic [23:0] TMO_LAST  = 24'(CLKS_TIMEOUT - 2);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_CSUM = 2'b01;
    localparam logic [1:0] CODE_LEN  = 2'b10;
    localparam logic [1:0] CODE_TMO  = 2'b11;

    // FSM state; kept as a named signal so checkers can bind to it.
    state_t      state_q, state_d;

    logic [7:0]  addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  sum_q, sum_d;
    // Payload index while collecting, write index while replaying.
    logic [7:0]  idx_q, idx_d;
    logic [23:0] tmo_q, tmo_d;

    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic        busy_q, busy_d;

    logic [7:0]  buf_mem [0:MAX_LEN-1];
    logic        buf_we;
    logic        timed;
    logic        timeout_hit;

    // Payload buffer: written while collecting, contents need no reset.
    always_ff @(posedge i_Clock) begin
        if (buf_we) begin
            buf_mem[idx_q[IDX_W-1:0]] <= i_Rx_Byte;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= IDLE;
            addr_q    <= 8'd0;
            len_q     <= 8'd0;
            sum_q     <= 8'd0;
            idx_q     <= 8'd0;
            tmo_q     <= 24'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 8'd0;
            wr_data_q <= 8'd0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= CODE_NONE;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            code_q    <= code_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state, frame assembly, timeout and replay logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        code_d      = code_q;
        buf_we      = 1'b0;

        timed       = (state_q == ADDR) || (state_q == LEN) ||
                      (state_q == DATA) || (state_q == CSUM);
        // A byte in the same cycle as the timeout keeps the frame alive.
        timeout_hit = timed && !i_Rx_DV && (tmo_q == TMO_LAST);

        if (timed) begin
            tmo_d = i_Rx_DV ? 24'd0 : tmo_q + 24'd1;
        end

        case (state_q)
            IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == HEADER)) begin
                    state_d = ADDR;
                    tmo_d   = 24'd0;
                end
            end
            ADDR: begin
                if (i_Rx_DV) begin
                    addr_d  = i_Rx_Byte;
                    sum_d   = i_Rx_Byte;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (i_Rx_DV) begin
                    if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > MAX_LEN_B)) begin
                        err_d   = 1'b1;
                        code_d  = CODE_LEN;
                        state_d = IDLE;
                    end else begin
                        len_d   = i_Rx_Byte;
                        sum_d   = sum_q + i_Rx_Byte;
                        idx_d   = 8'd0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (i_Rx_DV) begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + i_Rx_Byte;
                    if (idx_q == (len_q - 8'd1)) begin
                        state_d = CSUM;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            CSUM: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == sum_q) begin
                        // First write leaves on the next cycle; idx counts writes issued.
                        state_d   = REPLAY;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = buf_mem[0];
                        idx_d     = 8'd1;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = CODE_CSUM;
                        state_d = IDLE;
                    end
                end
            end
            REPLAY: begin
                if (idx_q == len_q) begin
                    ok_d    = 1'b1;
                    code_d  = CODE_NONE;
                    state_d = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q + idx_q;
                    wr_data_d = buf_mem[idx_q[IDX_W-1:0]];
                    idx_d     = idx_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (timeout_hit) begin
            err_d   = 1'b1;
            code_d  = CODE_TMO;
            state_d = IDLE;
        end

        busy_d = (state_d != IDLE) || err_d || ok_d;
    end

    assign o_Wr_En     = wr_en_q;
    assign o_Wr_Addr   = wr_addr_q;
    assign o_Wr_Data   = wr_data_q;
    assign o_Frame_Ok  = ok_q;
    assign o_Frame_Err = err_q;
    assign o_Err_Code  = code_q;
    assign o_Busy      = busy_q;

endmodule
